// File: rtl/branch_target_predictor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : branch_target_predictor                                    |
// | Description : Direct-mapped branch target buffer with 2-bit saturating   |
// |               direction counters, combinational IF-stage lookup, EX-stage|
// |               update with mispredict flag, and saturating statistics.    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module branch_target_predictor #(
  parameter int         XLEN     = 32,
  parameter int         ENTRIES  = 16,
  parameter logic [1:0] CNT_INIT = 2'b01,
  parameter int         STAT_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [XLEN-1:0]   lk_pc,
  output logic              lk_hit,
  output logic              lk_taken,
  output logic [XLEN-1:0]   lk_target,
  input  logic              upd_valid,
  input  logic [XLEN-1:0]   upd_pc,
  input  logic              upd_taken,
  input  logic [XLEN-1:0]   upd_target,
  input  logic              upd_pred_taken,
  input  logic [XLEN-1:0]   upd_pred_target,
  output logic              mispredict,
  input  logic              clear,
  output logic [STAT_W-1:0] stat_branches,
  output logic [STAT_W-1:0] stat_mispred
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;
  localparam logic [XLEN-1:0] c_pc_step = XLEN'(4);

  logic              r_valid  [ENTRIES];
  logic [TAG_W-1:0]  r_tag    [ENTRIES];
  logic [XLEN-1:0]   r_target [ENTRIES];
  logic [1:0]        r_cnt    [ENTRIES];

  logic [STAT_W-1:0] r_stat_branches;
  logic [STAT_W-1:0] r_stat_mispred;

  logic [IDX_W-1:0]  w_lk_idx;
  logic [TAG_W-1:0]  w_lk_tag;
  logic              w_lk_hit;
  logic              w_lk_taken;
  logic [IDX_W-1:0]  w_upd_idx;
  logic [TAG_W-1:0]  w_upd_tag;
  logic              w_upd_hit;
  logic              w_mispredict;

  assign w_lk_idx  = lk_pc[IDX_W+1:2];
  assign w_lk_tag  = lk_pc[XLEN-1:IDX_W+2];
  assign w_upd_idx = upd_pc[IDX_W+1:2];
  assign w_upd_tag = upd_pc[XLEN-1:IDX_W+2];

  // Lookup: read the indexed entry; outputs are forced to "not taken, pc+4" while in reset
  always_comb begin
    w_lk_hit   = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
    w_lk_taken = w_lk_hit && r_cnt[w_lk_idx][1];
    lk_hit     = w_lk_hit && !reset;
    lk_taken   = w_lk_taken && !reset;
    lk_target  = lk_taken ? r_target[w_lk_idx] : (lk_pc + c_pc_step);
  end

  // Resolution check: wrong direction, or right direction taken to the wrong target
  always_comb begin
    w_upd_hit    = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);
    w_mispredict = upd_valid &&
                   ((upd_taken != upd_pred_taken) ||
                    (upd_taken && (upd_target != upd_pred_target)));
    mispredict   = w_mispredict && !reset;
  end

  generate
    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
      localparam logic [IDX_W-1:0] c_idx = IDX_W'(gi);

      // Per-entry storage: clear wins over update; hits train the counter, taken misses allocate
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_valid[gi]  <= 1'b0;
          r_tag[gi]    <= '0;
          r_target[gi] <= '0;
          r_cnt[gi]    <= CNT_INIT;
        end else if (clear) begin
          r_valid[gi] <= 1'b0;
          r_cnt[gi]   <= CNT_INIT;
        end else if (upd_valid && (w_upd_idx == c_idx)) begin
          if (w_upd_hit) begin
            if (upd_taken) begin
              r_target[gi] <= upd_target;
              if (r_cnt[gi] != 2'b11) r_cnt[gi] <= r_cnt[gi] + 2'b01;
            end else begin
              if (r_cnt[gi] != 2'b00) r_cnt[gi] <= r_cnt[gi] - 2'b01;
            end
          end else if (upd_taken) begin
            r_valid[gi]  <= 1'b1;
            r_tag[gi]    <= w_upd_tag;
            r_target[gi] <= upd_target;
            r_cnt[gi]    <= 2'b10;
          end
        end
      end
    end
  endgenerate

  // Statistics: count every resolved branch and every flush, holding at all-ones
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stat_branches <= '0;
      r_stat_mispred  <= '0;
    end else begin
      if (upd_valid && !(&r_stat_branches))
        r_stat_branches <= r_stat_branches + 1'b1;
      if (w_mispredict && !(&r_stat_mispred))
        r_stat_mispred <= r_stat_mispred + 1'b1;
    end
  end

  assign stat_branches = r_stat_branches;
  assign stat_mispred  = r_stat_mispred;

endmodule
`default_nettype wire

// File: tb/tb_branch_target_predictor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_branch_target_predictor                                 |
// | Description : Directed self-checking bench for branch_target_predictor;  |
// |               a second instance with 4-bit stats shares all inputs.      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_branch_target_predictor;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] lk_pc;
  logic        upd_valid, upd_taken, upd_pred_taken, clear;
  logic [31:0] upd_pc, upd_target, upd_pred_target;

  logic        lk_hit, lk_taken, mispredict;
  logic [31:0] lk_target;
  logic [15:0] stat_branches, stat_mispred;

  logic        s_lk_hit, s_lk_taken, s_mispredict;
  logic [31:0] s_lk_target;
  logic [3:0]  s_stat_branches, s_stat_mispred;

  int total = 0;
  int bad   = 0;

  branch_target_predictor dut (
    .clk(clk), .reset(reset), .lk_pc(lk_pc), .lk_hit(lk_hit), .lk_taken(lk_taken),
    .lk_target(lk_target), .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
    .upd_pred_target(upd_pred_target), .mispredict(mispredict), .clear(clear),
    .stat_branches(stat_branches), .stat_mispred(stat_mispred)
  );

  branch_target_predictor #(.STAT_W(4)) dut4 (
    .clk(clk), .reset(reset), .lk_pc(lk_pc), .lk_hit(s_lk_hit), .lk_taken(s_lk_taken),
    .lk_target(s_lk_target), .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
    .upd_pred_target(upd_pred_target), .mispredict(s_mispredict), .clear(clear),
    .stat_branches(s_stat_branches), .stat_mispred(s_stat_mispred)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Combinational lookup, checked 1 time unit after lk_pc changes
  task automatic look(input logic [31:0] pc, input logic eh, input logic et,
                      input logic [31:0] etgt);
    lk_pc = pc;
    #1;
    chk("lk_hit", 64'(lk_hit), 64'(eh));
    chk("lk_taken", 64'(lk_taken), 64'(et));
    chk("lk_target", 64'(lk_target), 64'(etgt));
  endtask

  // One resolved branch: check the flush flag, then let it commit at the next edge
  task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                     input logic ptk, input logic [31:0] ptgt, input logic emis);
    upd_valid = 1'b1; upd_pc = pc; upd_taken = tk; upd_target = tgt;
    upd_pred_taken = ptk; upd_pred_target = ptgt;
    #1;
    chk("mispredict", 64'(mispredict), 64'(emis));
    @(posedge clk); #1;
    upd_valid = 1'b0;
  endtask

  task automatic stats(input int eb, input int em);
    chk("stat_branches", 64'(stat_branches), 64'(eb));
    chk("stat_mispred", 64'(stat_mispred), 64'(em));
  endtask

  initial begin
    // 1: reset state, outputs gated even with a mismatching update presented
    reset = 1'b1; clear = 1'b0; lk_pc = 32'h100;
    upd_valid = 1'b1; upd_pc = 32'h100; upd_taken = 1'b1; upd_target = 32'h40;
    upd_pred_taken = 1'b0; upd_pred_target = 32'h0;
    #2;
    chk("rst_hit", 64'(lk_hit), 64'd0);
    chk("rst_taken", 64'(lk_taken), 64'd0);
    chk("rst_target", 64'(lk_target), 64'h104);
    chk("rst_mispredict", 64'(mispredict), 64'd0);
    upd_valid = 1'b0;
    #6 reset = 1'b0;
    @(posedge clk); #1;
    stats(0, 0);
    chk("rst_s4_branches", 64'(s_stat_branches), 64'd0);

    // 2: taken allocation with mispredict; lookup before the edge sees old contents
    look(32'h100, 1'b0, 1'b0, 32'h104);
    upd(32'h100, 1'b1, 32'h40, 1'b0, 32'h0, 1'b1);
    look(32'h100, 1'b1, 1'b1, 32'h40);
    stats(1, 1);

    // 3: counter walks down to 00 and clamps, then up to 11 and clamps
    upd(32'h100, 1'b0, 32'h99C, 1'b1, 32'h40, 1'b1);   // 10 -> 01
    look(32'h100, 1'b1, 1'b0, 32'h104);
    upd(32'h100, 1'b0, 32'h99C, 1'b0, 32'h0, 1'b0);    // 01 -> 00
    look(32'h100, 1'b1, 1'b0, 32'h104);
    upd(32'h100, 1'b0, 32'h99C, 1'b0, 32'h0, 1'b0);    // 00 stays
    look(32'h100, 1'b1, 1'b0, 32'h104);
    upd(32'h100, 1'b1, 32'h40, 1'b1, 32'h40, 1'b0);    // 00 -> 01
    look(32'h100, 1'b1, 1'b0, 32'h104);
    upd(32'h100, 1'b1, 32'h40, 1'b1, 32'h40, 1'b0);    // 01 -> 10
    look(32'h100, 1'b1, 1'b1, 32'h40);
    upd(32'h100, 1'b1, 32'h40, 1'b1, 32'h40, 1'b0);    // 10 -> 11
    upd(32'h100, 1'b1, 32'h48, 1'b1, 32'h40, 1'b1);    // 11 stays, wrong target
    upd(32'h100, 1'b0, 32'h200, 1'b0, 32'h0, 1'b0);    // 11 -> 10, target kept
    look(32'h100, 1'b1, 1'b1, 32'h48);
    stats(9, 3);

    // 4: aliasing on index 0, not-taken miss leaves the entry alone
    look(32'h140, 1'b0, 1'b0, 32'h144);
    upd(32'h140, 1'b0, 32'h80, 1'b0, 32'h0, 1'b0);
    look(32'h100, 1'b1, 1'b1, 32'h48);
    upd(32'h140, 1'b1, 32'h80, 1'b0, 32'h0, 1'b1);
    look(32'h140, 1'b1, 1'b1, 32'h80);
    look(32'h100, 1'b0, 1'b0, 32'h104);
    upd(32'h208, 1'b1, 32'h300, 1'b1, 32'h300, 1'b0);
    look(32'h20A, 1'b1, 1'b1, 32'h300);
    stats(12, 4);

    // 5: clear beats a same-cycle update, stats still count it
    clear = 1'b1;
    upd_valid = 1'b1; upd_pc = 32'h30C; upd_taken = 1'b1; upd_target = 32'h10;
    upd_pred_taken = 1'b0; upd_pred_target = 32'h0;
    #1;
    chk("clr_mispredict", 64'(mispredict), 64'd1);
    @(posedge clk); #1;
    clear = 1'b0; upd_valid = 1'b0;
    look(32'h140, 1'b0, 1'b0, 32'h144);
    look(32'h208, 1'b0, 1'b0, 32'h20C);
    look(32'h30C, 1'b0, 1'b0, 32'h310);
    stats(13, 5);

    // 6: 4-bit stats saturate, then an async reset pulse between edges
    for (int i = 0; i < 20; i++)
      upd(32'h400, 1'b1, 32'h500, 1'b0, 32'h0, 1'b1);
    chk("s4_branches_sat", 64'(s_stat_branches), 64'd15);
    chk("s4_mispred_sat", 64'(s_stat_mispred), 64'd15);
    stats(33, 25);
    look(32'h400, 1'b1, 1'b1, 32'h500);
    #1 reset = 1'b1;
    #1;
    chk("arst_hit", 64'(lk_hit), 64'd0);
    chk("arst_target", 64'(lk_target), 64'h404);
    stats(0, 0);
    chk("arst_s4_branches", 64'(s_stat_branches), 64'd0);
    chk("arst_s4_mispred", 64'(s_stat_mispred), 64'd0);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("post_arst_hit", 64'(lk_hit), 64'd0);
    chk("post_arst_target", 64'(lk_target), 64'h404);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
